branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//   Pipelined branch/jump resolution unit for the multi-stage core.
//   - Resolves all RV32 conditional branches (signed and unsigned), JAL and JALR.
//   - Computes the target address and the redirect address.
//   - Compares the outcome with the front-end prediction and flags a mispredict.
//   - Trains a PC-indexed table of 2-bit saturating counters (BHT).
//   The BHT has a combinational lookup port for the fetch stage.
//   Sits between the execute stage and the fetch redirect logic.
// PARAMETERS
//   AW          32  address width
//   DW          32  data width (rs1/rs2/imm)
//   BHT_ENTRIES 64  number of BHT counters; power of two, >=2
//   PERF_W      32  width of the mispredict performance counter
// PORTS
//   clk           in   1    clock, rising edge
//   rst           in   1    reset, asynchronous, active-high
//   in_valid      in   1    resolve request valid
//   in_ready      out  1    unit can accept a request
//   func3         in   3    branch func3 (000 beq,001 bne,100 blt,101 bge,110 bltu,111 bgeu)
//   is_jal        in   1    request is JAL (overrides func3)
//   is_jalr       in   1    request is JALR (overrides func3 and is_jal)
//   pc            in   AW   PC of the control-flow instruction
//   imm           in   DW   sign-extended immediate
//   rs1_data      in   DW   rs1 operand
//   rs2_data      in   DW   rs2 operand
//   pred_taken    in   1    taken/not-taken prediction made at fetch
//   out_valid     out  1    result valid
//   out_ready     in   1    downstream accepts result
//   taken         out  1    resolved direction
//   target        out  AW   taken target address
//   redirect_pc   out  AW   taken ? target : pc+4
//   mispredict    out  1    taken != pred_taken
//   illegal       out  1    func3 is 010/011 with no jump flag
//   lookup_pc     in   AW   fetch-stage PC to predict
//   lookup_taken  out  1    MSB of the indexed BHT counter (combinational)
//   mispred_cnt   out  PERF_W  saturating count of mispredicts
// BEHAVIOUR
//   - Handshake
//     - in_ready = !out_valid || out_ready.
//     - A request is accepted when in_valid && in_ready.
//     - Latency 1: all result fields are registered on accept; out_valid is set the next cycle.
//     - out_valid and the result fields hold stable while out_valid && !out_ready.
//     - out_valid clears on out_ready when there is no new accept.
//     - Back-to-back accepts are allowed: full throughput with out_ready held high.
//   - Compare
//     - 100/101 use signed compare; 110/111 use unsigned compare.
//     - 000/001 use equality.
//     - 010/011 with no jump flag: taken=0, illegal=1, mispredict=pred_taken.
//     - Jumps (JAL or JALR): taken=1, illegal=0.
//   - Target arithmetic (modulo 2^AW, carry out discarded)
//     - Branch or JAL: target = pc+imm.
//     - JALR: target = (rs1_data+imm) & ~1.
//     - pc+4 wraps at 2^AW.
//   - BHT
//     - Index = pc[IDXW+1:2], where IDXW = $clog2(BHT_ENTRIES).
//     - Trained on accept of a legal conditional branch only; jumps and illegal requests do not train.
//     - taken: counter increments, saturating at 11.
//     - not taken: counter decrements, saturating at 00.
//     - lookup_taken reads the pre-update value. An update in cycle N is visible to lookup from cycle N+1.
//     - A lookup and an update to the same index in the same cycle: the lookup returns the old value.
//   - mispred_cnt increments at accept time when the computed mispredict=1; it saturates at all-ones.
//   - Reset (async assert, sync use after deassert)
//     - Outputs: out_valid=0, taken=0, target=0, redirect_pc=0, mispredict=0, illegal=0, mispred_cnt=0.
//     - All BHT counters reset to 01 (weakly not-taken), so lookup_taken=0.
//     - Reset mid-transfer drops the pending result; nothing is replayed.
// TESTING
//   - blt rs1=0xFFFFFFFF rs2=1 pc=0x100 imm=0x20 pred=0 -> taken=1, target=0x120, mispredict=1, mispred_cnt=1.
//   - bltu with the same operands -> taken=0, redirect_pc=0x104, mispredict=0.
//   - jalr rs1=0x2003 imm=4 -> target=0x2006, taken=1, no BHT change.
//   - Three taken beq at pc=0x40, lookup_pc=0x40 each cycle -> lookup_taken 0,1,1. Counter reads 01,10,11 and saturates at 11.
//   - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and the result holds. One accept follows when out_ready rises.
//   - func3=010 -> illegal=1, taken=0, BHT unchanged. Assert rst mid-stall -> out_valid=0 immediately and BHT back to 01.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: it evaluates the branch condition, computes the target and
// redirect PC, detects mispredicts and trains a PC-indexed 2-bit BHT that fetch can read combinationally.
module branch_resolve_unit #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        func3,
   input  logic              is_jal,
   input  logic              is_jalr,
   input  logic [AW-1:0]     pc,
   input  logic [DW-1:0]     imm,
   input  logic [DW-1:0]     rs1_data,
   input  logic [DW-1:0]     rs2_data,
   input  logic              pred_taken,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              taken,
   output logic [AW-1:0]     target,
   output logic [AW-1:0]     redirect_pc,
   output logic              mispredict,
   output logic              illegal,
   input  logic [AW-1:0]     lookup_pc,
   output logic              lookup_taken,
   output logic [PERF_W-1:0] mispred_cnt
);

   localparam int IDXW = $clog2(BHT_ENTRIES);

   logic              out_valid_q, out_valid_d;
   logic              taken_q, taken_d;
   logic [AW-1:0]     target_q, target_d;
   logic [AW-1:0]     redirect_pc_q, redirect_pc_d;
   logic              mispredict_q, mispredict_d;
   logic              illegal_q, illegal_d;
   logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;
   logic [1:0]        bht_q [BHT_ENTRIES];
   logic [1:0]        bht_d [BHT_ENTRIES];

   logic              accept, is_jump, train;
   logic              c_taken, c_illegal, c_mispredict;
   logic [AW-1:0]     c_target, c_redirect;
   logic [IDXW-1:0]   upd_idx, lkp_idx;
   logic              unused_lookup_bits;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign is_jump  = is_jal || is_jalr;
   assign upd_idx  = pc[IDXW+1:2];
   assign lkp_idx  = lookup_pc[IDXW+1:2];
   assign unused_lookup_bits = ^{lookup_pc[AW-1:IDXW+2], lookup_pc[1:0]};

   always_comb begin
      c_taken   = 1'b0;
      c_illegal = 1'b0;
      if (is_jump) begin
         c_taken = 1'b1;
      end else begin
         unique case (func3)
            3'b000:  c_taken = (rs1_data == rs2_data);
            3'b001:  c_taken = (rs1_data != rs2_data);
            3'b100:  c_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  c_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  c_taken = (rs1_data <  rs2_data);
            3'b111:  c_taken = (rs1_data >= rs2_data);
            default: c_illegal = 1'b1;
         endcase
      end
      // JALR clears bit 0 of the sum; every other target is PC-relative.
      if (is_jalr)
         c_target = (AW'(rs1_data) + AW'(imm)) & ~AW'(1);
      else
         c_target = pc + AW'(imm);
      c_redirect   = c_taken ? c_target : pc + AW'(4);
      c_mispredict = (c_taken != pred_taken);
   end

   assign train = accept && !is_jump && !c_illegal;

   always_comb begin
      out_valid_d   = out_valid_q;
      taken_d       = taken_q;
      target_d      = target_q;
      redirect_pc_d = redirect_pc_q;
      mispredict_d  = mispredict_q;
      illegal_d     = illegal_q;
      mispred_cnt_d = mispred_cnt_q;
      bht_d         = bht_q;
      if (accept) begin
         out_valid_d   = 1'b1;
         taken_d       = c_taken;
         target_d      = c_target;
         redirect_pc_d = c_redirect;
         mispredict_d  = c_mispredict;
         illegal_d     = c_illegal;
         if (c_mispredict && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (train) begin
         if (c_taken && (bht_q[upd_idx] != 2'b11))
            bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
         else if (!c_taken && (bht_q[upd_idx] != 2'b00))
            bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         taken_q       <= 1'b0;
         target_q      <= '0;
         redirect_pc_q <= '0;
         mispredict_q  <= 1'b0;
         illegal_q     <= 1'b0;
         mispred_cnt_q <= '0;
         // NOTE: the BHT is a flop array, not RAM, so every counter can be reset to weakly not-taken.
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else begin
         out_valid_q   <= out_valid_d;
         taken_q       <= taken_d;
         target_q      <= target_d;
         redirect_pc_q <= redirect_pc_d;
         mispredict_q  <= mispredict_d;
         illegal_q     <= illegal_d;
         mispred_cnt_q <= mispred_cnt_d;
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
      end
   end

   assign out_valid    = out_valid_q;
   assign taken        = taken_q;
   assign target       = target_q;
   assign redirect_pc  = redirect_pc_q;
   assign mispredict   = mispredict_q;
   assign illegal      = illegal_q;
   assign mispred_cnt  = mispred_cnt_q;
   assign lookup_taken = bht_q[lkp_idx][1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized requests
// compared against an instruction-level reference model of the resolution rules and the BHT.
module tb_branch_resolve_unit;

   logic        clk, rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  func3;
   logic        is_jal, is_jalr, pred_taken;
   logic [31:0] pc, imm, rs1_data, rs2_data, lookup_pc;
   logic        taken, mispredict, illegal, lookup_taken;
   logic [31:0] target, redirect_pc, mispred_cnt;

   typedef struct {
      logic        taken;
      logic [31:0] target;
      logic [31:0] redirect;
      logic        mis;
      logic        ill;
   } res_t;

   int          errors = 0;
   int          checks = 0;
   int          bht_m [64];
   int unsigned cnt_m;

   branch_resolve_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .func3(func3), .is_jal(is_jal), .is_jalr(is_jalr), .pc(pc), .imm(imm),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .pred_taken(pred_taken),
      .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
      .redirect_pc(redirect_pc), .mispredict(mispredict), .illegal(illegal),
      .lookup_pc(lookup_pc), .lookup_taken(lookup_taken), .mispred_cnt(mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the architectural meaning of each instruction, evaluated on plain integers.
   function automatic res_t ref_resolve(input logic [2:0] f3, input logic jal, input logic jalr,
                                        input logic [31:0] p, input logic [31:0] im,
                                        input logic [31:0] a, input logic [31:0] b, input logic pr);
      res_t        r;
      longint      sa, sb;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      r.ill = 1'b0;
      if (jal || jalr) r.taken = 1'b1;
      else if (f3 == 3'd0) r.taken = (ua == ub);
      else if (f3 == 3'd1) r.taken = (ua != ub);
      else if (f3 == 3'd4) r.taken = (sa < sb);
      else if (f3 == 3'd5) r.taken = (sa >= sb);
      else if (f3 == 3'd6) r.taken = (ua < ub);
      else if (f3 == 3'd7) r.taken = (ua >= ub);
      else begin
         r.taken = 1'b0;
         r.ill   = 1'b1;
      end
      if (jalr) r.target = 32'((ua + longint'(im)) % 64'h1_0000_0000) & 32'hFFFF_FFFE;
      else      r.target = 32'((longint'(p) + longint'(im)) % 64'h1_0000_0000);
      r.redirect = r.taken ? r.target : 32'((longint'(p) + 4) % 64'h1_0000_0000);
      r.mis      = (r.taken != pr);
      return r;
   endfunction

   // Apply the side effects of an accepted request to the model state.
   task automatic model_accept(input res_t r, input logic jump, input logic [31:0] p);
      int idx;
      idx = int'(p[7:2]);
      if (!jump && !r.ill) begin
         if (r.taken) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
         else         bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
      end
      if (r.mis && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
   endtask

   task automatic check_out(input string name, input res_t e);
      checks += 6;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid got %b want 1", name, out_valid); end
      if (taken !== e.taken) begin errors++; $display("FAIL %s taken got %b want %b", name, taken, e.taken); end
      if (target !== e.target) begin errors++; $display("FAIL %s target got %h want %h", name, target, e.target); end
      if (redirect_pc !== e.redirect) begin errors++; $display("FAIL %s redirect_pc got %h want %h", name, redirect_pc, e.redirect); end
      if (mispredict !== e.mis || illegal !== e.ill) begin
         errors++;
         $display("FAIL %s mispredict/illegal got %b/%b want %b/%b", name, mispredict, illegal, e.mis, e.ill);
      end
      if (mispred_cnt !== cnt_m) begin errors++; $display("FAIL %s mispred_cnt got %0d want %0d", name, mispred_cnt, cnt_m); end
   endtask

   task automatic drive(input logic [2:0] f3, input logic jal, input logic jalr, input logic [31:0] p,
                        input logic [31:0] im, input logic [31:0] a, input logic [31:0] b, input logic pr);
      func3 = f3; is_jal = jal; is_jalr = jalr; pc = p; imm = im;
      rs1_data = a; rs2_data = b; pred_taken = pr;
   endtask

   // One request with out_ready high; lookup on the same PC checks the pre-update counter.
   task automatic do_req(input string name, input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [31:0] p, input logic [31:0] im, input logic [31:0] a,
                         input logic [31:0] b, input logic pr);
      res_t e;
      @(negedge clk);
      drive(f3, jal, jalr, p, im, a, b, pr);
      in_valid = 1'b1; out_ready = 1'b1; lookup_pc = p;
      #1;
      checks += 2;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b want 1", name, in_ready); end
      if (lookup_taken !== (bht_m[p[7:2]] >= 2)) begin
         errors++;
         $display("FAIL %s lookup_taken got %b want %b", name, lookup_taken, bht_m[p[7:2]] >= 2);
      end
      e = ref_resolve(f3, jal, jalr, p, im, a, b, pr);
      model_accept(e, jal || jalr, p);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_out(name, e);
   endtask

   task automatic apply_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; lookup_pc = '0;
      drive(3'd0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
      for (int i = 0; i < 64; i++) bht_m[i] = 1;
      cnt_m = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks += 3;
      if (out_valid !== 1'b0 || taken !== 1'b0 || mispredict !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got v=%b t=%b m=%b i=%b want all 0", out_valid, taken, mispredict, illegal);
      end
      if (target !== 32'h0 || redirect_pc !== 32'h0 || mispred_cnt !== 32'h0) begin
         errors++;
         $display("FAIL reset_values got %h/%h/%h want 0/0/0", target, redirect_pc, mispred_cnt);
      end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      for (int i = 0; i < 64; i += 9) begin
         lookup_pc = 32'(i * 4);
         #1;
         checks++;
         if (lookup_taken !== 1'b0) begin errors++; $display("FAIL reset_bht[%0d] got %b want 0", i, lookup_taken); end
      end
   endtask

   task automatic test_directed();
      do_req("blt_signed", 3'd4, 0, 0, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0);
      checks++;
      if (mispred_cnt !== 32'd1) begin errors++; $display("FAIL blt_cnt got %0d want 1", mispred_cnt); end
      do_req("bltu_unsigned", 3'd6, 0, 0, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0);
      checks++;
      if (redirect_pc !== 32'h104 || taken !== 1'b0) begin
         errors++; $display("FAIL bltu_redirect got %h/%b want 00000104/0", redirect_pc, taken);
      end
      do_req("jalr", 3'd0, 0, 1, 32'h40, 32'h4, 32'h2003, 32'h0, 1'b1);
      checks++;
      if (target !== 32'h2006) begin errors++; $display("FAIL jalr_target got %h want 00002006", target); end
      do_req("jal_wrap", 3'd2, 1, 0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 1'b0);
      // Four taken beq then three not-taken at 0x40: counter 01,10,11,11 then 11,10,01.
      for (int k = 0; k < 4; k++) do_req("beq_train", 3'd0, 0, 0, 32'h40, 32'h10, 32'h5, 32'h5, 1'b1);
      for (int k = 0; k < 3; k++) do_req("bne_untrain", 3'd1, 0, 0, 32'h40, 32'h10, 32'h5, 32'h5, 1'b0);
      @(negedge clk);
      lookup_pc = 32'h40;
      #1;
      checks++;
      if (lookup_taken !== 1'b0) begin errors++; $display("FAIL bht_after_untrain got %b want 0", lookup_taken); end
      do_req("bne_wrap_next", 3'd1, 0, 0, 32'hFFFF_FFFC, 32'h8, 32'h1, 32'h5, 1'b1);
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic        jal, jalr;
      logic [31:0] p, im, a, b;
      for (int n = 0; n < 300; n++) begin
         f3   = 3'($urandom_range(0, 7));
         jal  = ($urandom_range(0, 9) == 0);
         jalr = ($urandom_range(0, 9) == 0);
         p    = $urandom & 32'hFFFF_F01C;
         im   = ($urandom_range(0, 1) == 1) ? 32'($signed(12'($urandom))) : $urandom;
         a    = $urandom;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ 32'h8000_0000;
            default: b = $urandom;
         endcase
         do_req("random", f3, jal, jalr, p, im, a, b, 1'($urandom));
      end
   endtask

   task automatic test_back_to_back_stall();
      res_t ea, eb;
      do_req("stall_a", 3'd5, 0, 0, 32'h300, 32'h40, 32'h7, 32'hFFFF_FFF0, 1'b0);
      ea = ref_resolve(3'd5, 0, 0, 32'h300, 32'h40, 32'h7, 32'hFFFF_FFF0, 1'b0);
      @(negedge clk);
      drive(3'd7, 0, 0, 32'h304, 32'h80, 32'h3, 32'h9, 1'b1);
      in_valid = 1'b1; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
         @(posedge clk); #1;
         check_out("stall_hold", ea);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
      eb = ref_resolve(3'd7, 0, 0, 32'h304, 32'h80, 32'h3, 32'h9, 1'b1);
      model_accept(eb, 1'b0, 32'h304);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_out("stall_b", eb);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_illegal_reset();
      do_req("illegal_010", 3'd2, 0, 0, 32'h80, 32'h10, 32'h1, 32'h1, 1'b1);
      do_req("illegal_011", 3'd3, 0, 0, 32'h80, 32'h10, 32'h1, 32'h2, 1'b0);
      @(negedge clk);
      lookup_pc = 32'h80;
      #1;
      checks++;
      if (lookup_taken !== 1'b0 || bht_m[32] != 1) begin
         errors++; $display("FAIL illegal_no_train got %b want 0", lookup_taken);
      end
      do_req("train_200", 3'd0, 0, 0, 32'h200, 32'h4, 32'h0, 32'h0, 1'b0);
      do_req("train_200", 3'd0, 0, 0, 32'h200, 32'h4, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      drive(3'd0, 0, 0, 32'h200, 32'h4, 32'h0, 32'h0, 1'b0);
      in_valid = 1'b0; out_ready = 1'b0; lookup_pc = 32'h200;
      #1;
      checks++;
      if (lookup_taken !== 1'b1 || out_valid !== 1'b1) begin
         errors++; $display("FAIL pre_reset got lookup=%b valid=%b want 1/1", lookup_taken, out_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || lookup_taken !== 1'b0 || mispred_cnt !== 32'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset got valid=%b lookup=%b cnt=%0d ready=%b want 0/0/0/1",
                  out_valid, lookup_taken, mispred_cnt, in_ready);
      end
      for (int i = 0; i < 64; i++) bht_m[i] = 1;
      cnt_m = 0;
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      do_req("post_reset", 3'd0, 0, 0, 32'h200, 32'h4, 32'h0, 32'h0, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back_stall();
      test_illegal_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
